// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side blocks.
package uart_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of req scanning upward from ptr with wrap.
module rr_pick import uart_pkg::*; #(
    parameter  int N = 4,
    localparam int W = clog2_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        // Walk from the farthest offset down so the nearest hit to ptr wins.
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (req[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Per-message round-robin arbiter sharing one UART tx handshake among NREQ clients.
// Handshake: a byte moves when valid && ready in the same cycle; valid never waits on ready.
module uart_tx_arbiter import uart_pkg::*; #(
    parameter  int NREQ    = 4,
    parameter  int MAX_LEN = 0,
    localparam int IW      = clog2_w(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              gnt_valid,
    output logic [IW-1:0]     gnt_id
);

    localparam int            CW       = clog2_w(MAX_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'((MAX_LEN == 0) ? 0 : MAX_LEN - 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          xfer;

    rr_pick #(.N(NREQ)) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        xfer      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                tx_valid         = req_valid[gnt_q];
                tx_data          = req_data[{gnt_q, 3'b000} +: 8];
                req_ready[gnt_q] = tx_ready;
                xfer             = req_valid[gnt_q] && tx_ready;
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (req_last[gnt_q] || (MAX_LEN != 0 && cnt_q == LAST_CNT)) begin
                        state_d = IDLE;
                        ptr_d   = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_valid = (state_q == LOCKED);
    assign gnt_id    = gnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (no length limit, MAX_LEN=2) against a message-level model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   rv  [2];
    logic [NREQ*8-1:0] rd  [2];
    logic [NREQ-1:0]   rl  [2];
    logic [NREQ-1:0]   rr  [2];
    logic              txv [2];
    logic [7:0]        txd [2];
    logic              txr;
    logic              gv  [2];
    logic [1:0]        gid [2];

    uart_tx_arbiter #(.NREQ(NREQ), .MAX_LEN(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_data(rd[0]), .req_last(rl[0]),
        .req_ready(rr[0]), .tx_valid(txv[0]), .tx_data(txd[0]), .tx_ready(txr),
        .gnt_valid(gv[0]), .gnt_id(gid[0])
    );

    uart_tx_arbiter #(.NREQ(NREQ), .MAX_LEN(2)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_data(rd[1]), .req_last(rl[1]),
        .req_ready(rr[1]), .tx_valid(txv[1]), .tx_data(txd[1]), .tx_ready(txr),
        .gnt_valid(gv[1]), .gnt_id(gid[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // per-instance pending bytes of each requester: {last, data}
    logic [8:0]  mq [2][NREQ][$];
    logic [15:0] exp_q[$];

    int m_lock [2];
    int m_own  [2];
    int m_cnt  [2];
    int m_ptr  [2];
    int ml     [2] = '{0, 2};

    int hold [NREQ];
    int rdy_low;
    bit gap_mode;
    bit txr_rand;

    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lock[k] = 0;
            m_own[k]  = 0;
            m_cnt[k]  = 0;
            m_ptr[k]  = 0;
        end
    endtask

    task automatic push_msg(input int id, input int len, input int base, input bit rnd);
        logic [7:0] b;
        for (int n = 0; n < len; n++) begin
            b = rnd ? 8'($urandom_range(0, 255)) : 8'(base + n);
            for (int k = 0; k < 2; k++) mq[k][id].push_back({(n == len - 1), b});
        end
    endtask

    // driver: one cycle of stimulus, then compare against the model and advance it
    task automatic step();
        logic [NREQ-1:0] e_rdy;
        logic [8:0]      front;
        logic [15:0]     ent;
        int              own;
        bit              mx;
        @(negedge clk);
        if (rdy_low > 0) begin
            txr = 1'b0;
            rdy_low--;
        end else if (txr_rand) begin
            txr = ($urandom_range(0, 3) != 0);
        end else begin
            txr = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (mq[k][i].size() != 0 && hold[i] == 0 &&
                    !(gap_mode && $urandom_range(0, 3) == 0)) begin
                    front          = mq[k][i][0];
                    rv[k][i]       = 1'b1;
                    rd[k][i*8 +: 8] = front[7:0];
                    rl[k][i]       = front[8];
                end else begin
                    rv[k][i]       = 1'b0;
                    rd[k][i*8 +: 8] = 8'($urandom_range(0, 255));
                    rl[k][i]       = 1'($urandom_range(0, 1));
                end
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            own   = m_own[k];
            e_rdy = '0;
            if (m_lock[k] != 0 && txr) e_rdy[own] = 1'b1;
            check("gnt_valid", 32'(gv[k]), 32'(m_lock[k] != 0));
            check("gnt_id", 32'(gid[k]), 32'(own));
            check("tx_valid", 32'(txv[k]), 32'(m_lock[k] != 0 && rv[k][own]));
            check("req_ready", 32'(rr[k]), 32'(e_rdy));
            if (m_lock[k] != 0 && rv[k][own]) check("tx_data", 32'(txd[k]), 32'(rd[k][own*8 +: 8]));
            if (m_lock[k] == 0) begin
                for (int n = 0; n < NREQ; n++) begin
                    int id;
                    id = (m_ptr[k] + n) % NREQ;
                    if (m_lock[k] == 0 && rv[k][id]) begin
                        m_lock[k] = 1;
                        m_own[k]  = id;
                        m_cnt[k]  = 0;
                    end
                end
            end else if (rv[k][own] && txr) begin
                exp_q.push_back({4'(k), 4'(own), rd[k][own*8 +: 8]});
                void'(mq[k][own].pop_front());
                m_cnt[k]++;
                if (rl[k][own] || (ml[k] != 0 && m_cnt[k] == ml[k])) begin
                    m_lock[k] = 0;
                    m_ptr[k]  = (own + 1) % NREQ;
                end
            end
        end
        // scoreboard: every byte the core takes must be the next expected one
        for (int k = 0; k < 2; k++) begin
            if (txv[k] === 1'b1 && txr) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra", 32'(k), 32'hffff);
                end else begin
                    ent = exp_q.pop_front();
                    mx  = 1'b0;
                    check("sb_byte", {16'h0, 4'(k), 2'b00, gid[k], txd[k]}, 32'(ent));
                    if (mx) n_bad++;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) if (hold[i] > 0) hold[i]--;
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NREQ; i++) s += mq[k][i].size();
        return s;
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (pending() != 0 && n < 2000) begin
            step();
            n++;
        end
        for (int k = 0; k < 4; k++) step();
        check(tag, 32'(pending()), 32'h0);
        check({tag, "_sb"}, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic wait_owner(input string tag, input int id, input int c);
        int n;
        n = 0;
        while (!(m_lock[0] != 0 && m_own[0] == id && m_cnt[0] == c) && n < 200) begin
            step();
            n++;
        end
        check(tag, 32'(n < 200), 32'h1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_tx_valid", 32'(txv[k]), 32'h0);
            check("rst_gnt_valid", 32'(gv[k]), 32'h0);
            check("rst_req_ready", 32'(rr[k]), 32'h0);
        end
        model_reset();
        for (int k = 0; k < 2; k++) rv[k] = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rdy_low  = 0;
        gap_mode = 1'b0;
        txr_rand = 1'b0;
        txr      = 1'b1;
        for (int i = 0; i < NREQ; i++) hold[i] = 0;
        for (int k = 0; k < 2; k++) begin
            rv[k] = '0;
            rd[k] = '0;
            rl[k] = '0;
        end
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset_gnt_valid", 32'(gv[k]), 32'h0);
            check("reset_gnt_id", 32'(gid[k]), 32'h0);
            check("reset_tx_valid", 32'(txv[k]), 32'h0);
            check("reset_req_ready", 32'(rr[k]), 32'h0);
        end

        // single requester, three bytes, core always ready
        push_msg(1, 3, 'h41, 1'b0);
        drain("single_msg");

        // all four requesters with back-to-back one-byte messages
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) push_msg(i, 1, 'h10 * (i + 1) + r, 1'b0);
        drain("all_four");

        // long message from 0 with 2 pending (split on the MAX_LEN=2 instance)
        push_msg(0, 5, 'h50, 1'b0);
        step();
        push_msg(2, 1, 'h60, 1'b0);
        drain("max_len");

        // core stalls mid-message
        push_msg(3, 8, 'h70, 1'b0);
        push_msg(1, 2, 'h80, 1'b0);
        wait_owner("wait_stall", 3, 1);
        rdy_low = 10;
        drain("stall");

        // grantee pauses while others wait
        push_msg(1, 6, 'h90, 1'b0);
        wait_owner("wait_gap", 1, 2);
        push_msg(0, 1, 'ha0, 1'b0);
        push_msg(2, 1, 'ha1, 1'b0);
        push_msg(3, 1, 'ha2, 1'b0);
        hold[1] = 3;
        drain("gap");

        // reset in the middle of a message
        push_msg(2, 6, 'hb0, 1'b0);
        push_msg(3, 1, 'hc0, 1'b0);
        wait_owner("wait_rst", 2, 2);
        push_msg(1, 1, 'hc1, 1'b0);
        reset_pulse();
        drain("mid_reset");

        // randomized traffic
        gap_mode = 1'b1;
        txr_rand = 1'b1;
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                int id;
                id = $urandom_range(0, NREQ - 1);
                if (mq[0][id].size() < 8) push_msg(id, $urandom_range(1, 6), 0, 1'b1);
            end
            step();
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single transmit channel of the UART core among NREQ requesters. Grants the channel per message: the winner keeps it until it has sent a byte marked last, or until a byte-count limit forces release. Sits between the client blocks and the core's tx_valid/tx_data/tx_ready handshake.

## Interface
- NREQ, 4: number of requesters, 2..16.
- MAX_LEN, 0: maximum bytes per grant; 0 means no limit (release only on last).
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  NREQ  per-requester byte valid.
- req_data  input  NREQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  input  NREQ  byte is final of the requester's message.
- req_ready  output  NREQ  byte accepted from requester i when req_valid[i] && req_ready[i].
- tx_valid  output  1  to core tx_valid.
- tx_data  output  8  to core tx_data.
- tx_ready  input  1  from core tx_ready.
- gnt_valid  output  1  a grant is held.
- gnt_id  output  clog2(NREQ)  index of current or most recent grantee.

## Operation
- States: IDLE, LOCKED.
- IDLE: tx_valid=0, req_ready=0. If any req_valid, select the first set bit scanning from ptr upward with wrap (ptr, ptr+1, …, NREQ-1, 0, …). Register gnt_id = winner, clear cnt, go to LOCKED.
- LOCKED: tx_valid = req_valid[gnt_id]; tx_data = req_data[gnt_id]; req_ready[gnt_id] = tx_ready; every other req_ready = 0. Pure combinational passthrough, no data register.
- A transfer occurs when tx_valid && tx_ready. On each transfer, cnt increments. Width of cnt is clog2(MAX_LEN+1); saturating is not needed because release occurs at MAX_LEN.
- Release: on a transfer with req_last[gnt_id]=1, or with MAX_LEN≠0 and cnt==MAX_LEN-1, return to IDLE and set ptr = gnt_id+1, wrapping at NREQ.
- Requester dropping req_valid mid-message does not release the grant; the arbiter waits in LOCKED indefinitely.
- req_last is sampled only on a transfer cycle; req_last without req_valid is ignored.

## Timing
- Reset values: state=IDLE, ptr=0, gnt_id=0, cnt=0, gnt_valid=0, tx_valid=0, req_ready=0.
- Arbitration latency: req_valid high in cycle N while IDLE → gnt_valid and tx_valid high in cycle N+1.
- Release costs one IDLE cycle: last transfer in cycle M → IDLE in M+1 → next grant visible in M+2. Back-to-back messages therefore leave exactly one bubble.
- gnt_valid = (state==LOCKED); it is registered.
- Asynchronous reset mid-message drops tx_valid immediately. Any byte not yet accepted is lost; requesters must re-send it.
- tx_ready is assumed independent of tx_valid, so no combinational loop exists between core and arbiter.

## Structure
- A shared uart_pkg holds the state enum (IDLE, LOCKED) and the helper function for clog2 width.
- One sub-module: rr_pick, a combinational rotating-priority encoder with inputs req and ptr and outputs found and idx. It is reusable for a future RX router.
- Main module: state register, ptr, gnt_id, cnt, and the output muxes.

## Test plan
- Single requester 1 sends 3 bytes 0x41, 0x42, 0x43 with last on 0x43, and tx_ready is always 1. Expect tx_data 0x41, 0x42, 0x43 on consecutive cycles starting 1 cycle after req_valid. gnt_id=1. Afterwards ptr=2, and gnt_valid falls the cycle after 0x43.
- All 4 requesters continuously valid with 1-byte messages. Expect grant order 0,1,2,3,0 with one idle cycle between each.
- MAX_LEN=2, requester 0 sends a 5-byte message while requester 2 is pending. Expect 2 bytes from 0, then a grant to 2, then the remaining bytes of 0 on its next turn.
- tx_ready held low for 10 cycles mid-message. Expect tx_valid and tx_data stable, req_ready[gnt]=0, cnt unchanged, and no release.
- Assert rst for 1 cycle while LOCKED in the middle of a message. Expect tx_valid=0, gnt_valid=0, ptr=0 immediately. After reset deassertion, the next arbitration starts from requester 0.
- Grantee deasserts req_valid for 3 cycles mid-message while others are valid. Expect the grant to be held, tx_valid=0 during the gap, and no switch to another requester.
